spi_modport: RTL and testbench

Single-chip-select SPI master with four MOSI and four MISO lanes. It serializes a parallel word onto 1, 2 or 4 lanes and captures the returned word in full duplex, in all four CPOL/CPHA modes. It sits between a register-level host (start/data/done handshake) and the pin-level SPI bus (`sclk`, `cs`, `mosi0..3`, `miso0..3`) that the verification agents drive and sample.

---
 rtl/spi_modport.sv | 195 +++++++++++++++++++
 tb/tb_spi_modport.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_modport.sv
// rtl/spi_modport.sv - single-CS SPI master, 1/2/4 lanes, all CPOL/CPHA modes, full duplex.
// Start/done host handshake on one side, registered pin-level SPI bus on the other.
module spi_modport #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [1:0]            lanes,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs,
  output logic                  mosi0,
  output logic                  mosi1,
  output logic                  mosi2,
  output logic                  mosi3,
  input  logic                  miso0,
  input  logic                  miso1,
  input  logic                  miso2,
  input  logic                  miso3
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW   = $clog2(2 * DATA_WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rxs_q, rxs_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [1:0]            wsel_q, wsel_d;
  logic                  cpha_q, cpha_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic [3:0]            mosi_q, mosi_d;

  logic                  tick;
  logic                  leading;
  logic                  last_edge;
  logic [EW-1:0]         edge_k;
  logic [EW-1:0]         total_edges;
  logic [1:0]            wsel_start;
  logic [3:0]            miso_vec;

  // Lane select: 0 = single, 1 = dual, 2 = quad; MSB of the chunk rides the highest active lane.
  function automatic logic [3:0] chunk_of(input logic [DATA_WIDTH-1:0] w, input logic [1:0] sel);
    case (sel)
      2'd0:    chunk_of = {3'b000, w[DATA_WIDTH-1]};
      2'd1:    chunk_of = {2'b00, w[DATA_WIDTH-1 -: 2]};
      default: chunk_of = w[DATA_WIDTH-1 -: 4];
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] sel);
    case (sel)
      2'd0:    tx_shift = w << 1;
      2'd1:    tx_shift = w << 2;
      default: tx_shift = w << 4;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [1:0] sel,
                                                     input logic [3:0] m);
    case (sel)
      2'd0:    rx_shift = {w[DATA_WIDTH-2:0], m[0]};
      2'd1:    rx_shift = {w[DATA_WIDTH-3:0], m[1:0]};
      default: rx_shift = {w[DATA_WIDTH-5:0], m[3:0]};
    endcase
  endfunction

  assign miso_vec    = {miso3, miso2, miso1, miso0};
  assign wsel_start  = (lanes == 2'b11) ? 2'b00 : lanes;
  assign tick        = (div_q == DIVW'(CLK_DIV - 1));
  assign edge_k      = edge_q + EW'(1);
  assign total_edges = EW'(2 * DATA_WIDTH) >> wsel_q;
  assign last_edge   = (edge_k == total_edges);
  assign leading     = edge_k[0];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    wsel_d  = wsel_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        cs_d   = 1'b1;
        mosi_d = 4'd0;
        if (start) begin
          state_d = S_LEAD;
          cs_d    = 1'b0;
          div_d   = '0;
          edge_d  = '0;
          wsel_d  = wsel_start;
          cpha_d  = cpha;
          rxs_d   = '0;
          if (cpha) begin
            tx_d = tx_data;
          end else begin
            mosi_d = chunk_of(tx_data, wsel_start);
            tx_d   = tx_shift(tx_data, wsel_start);
          end
        end
      end
      S_LEAD, S_XFER: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          edge_d  = edge_k;
          sclk_d  = ~sclk_q;
          state_d = last_edge ? S_TRAIL : S_XFER;
          // Sampling edge is leading for CPHA=0 and trailing for CPHA=1; the other edge drives.
          if (leading ^ cpha_q) begin
            rxs_d = rx_shift(rxs_q, wsel_q, miso_vec);
          end else if (cpha_q || !last_edge) begin
            mosi_d = chunk_of(tx_q, wsel_q);
            tx_d   = tx_shift(tx_q, wsel_q);
          end
        end
      end
      S_TRAIL: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          state_d = S_FINISH;
          cs_d    = 1'b1;
          mosi_d  = 4'd0;
          rx_d    = rxs_q;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rxs_q   <= '0;
      rx_q    <= '0;
      wsel_q  <= 2'b00;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      wsel_q  <= wsel_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy    = (state_q == S_LEAD) || (state_q == S_XFER) || (state_q == S_TRAIL);
  assign done    = (state_q == S_FINISH);
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi0   = mosi_q[0];
  assign mosi1   = mosi_q[1];
  assign mosi2   = mosi_q[2];
  assign mosi3   = mosi_q[3];

endmodule

// File: tb/tb_spi_modport.sv
// tb/tb_spi_modport.sv - scoreboard bench for spi_modport with a pin-level SPI slave model.
module tb_spi_modport;

  localparam int DW = 8;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          rst, start, cpol, cpha;
  logic [DW-1:0] tx_data;
  logic [1:0]    lanes;
  logic          busy, done, sclk, cs;
  logic          mosi0, mosi1, mosi2, mosi3;
  logic          miso0, miso1, miso2, miso3;
  logic [DW-1:0] rx_data;

  spi_modport #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cpol(cpol), .cpha(cpha),
    .lanes(lanes), .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk), .cs(cs),
    .mosi0(mosi0), .mosi1(mosi1), .mosi2(mosi2), .mosi3(mosi3),
    .miso0(miso0), .miso1(miso1), .miso2(miso2), .miso3(miso3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         w;
    int         t0;
    bit         gap;
  } exp_t;

  typedef struct {
    logic [7:0] word;
    int         w;
    bit         pol;
    bit         pha;
  } slv_t;

  exp_t exp_q[$];
  slv_t slv_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dn_count = 0;
  int exp_dones = 0;
  int cs_fall_cyc = 0;
  int last_done_cyc = 0;

  slv_t       cur;
  bit         active = 0;
  bit         prev_cs = 1;
  logic       prev_sclk = 0;
  logic [3:0] prev_mosi = 0;
  logic [7:0] s_out, s_in;
  int         s_edges;
  bit         s_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task slave_drive();
    case (cur.w)
      1:       {miso3, miso2, miso1, miso0} = {3'b111, s_out[7]};
      2:       {miso3, miso2, miso1, miso0} = {2'b11, s_out[7:6]};
      default: {miso3, miso2, miso1, miso0} = s_out[7:4];
    endcase
    s_out = s_out << cur.w;
  endtask

  task slave_sample(input logic [3:0] m);
    case (cur.w)
      1: begin
        s_in = {s_in[6:0], m[0]};
        if (m[3:1] !== 3'b000) s_bad = 1;
      end
      2: begin
        s_in = {s_in[5:0], m[1:0]};
        if (m[3:2] !== 2'b00) s_bad = 1;
      end
      default: s_in = {s_in[3:0], m[3:0]};
    endcase
  endtask

  // Slave model and scoreboard monitor, evaluated away from the active edge.
  initial begin
    forever begin
      logic [3:0] m;
      bit         drv_edge;
      bit         lead;
      exp_t       e;
      @(negedge clk);
      m = {mosi3, mosi2, mosi1, mosi0};
      drv_edge = 0;
      if (prev_cs && !cs) begin
        if (slv_q.size() == 0) begin
          check("unexpected_cs_fall", 1, 0);
          cur = '{8'h00, 1, 1'b0, 1'b0};
        end else begin
          cur = slv_q.pop_front();
        end
        active      = 1;
        s_out       = cur.word;
        s_in        = 8'h00;
        s_edges     = 0;
        s_bad       = 0;
        cs_fall_cyc = cyc;
        if (!cur.pha) slave_drive();
      end else if (!cs && active) begin
        if (sclk !== prev_sclk) begin
          s_edges++;
          lead = (sclk !== cur.pol);
          if (lead ^ cur.pha) begin
            slave_sample(m);
          end else begin
            slave_drive();
            drv_edge = 1;
          end
        end
        if (m !== prev_mosi && !drv_edge) s_bad = 1;
      end

      if (done === 1'b1) begin
        dn_count++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.rx));
          check("mosi_word", 32'(s_in), 32'(e.tx));
          check("sclk_edges", 32'(s_edges), 32'(2 * DW / e.w));
          check("lane_stability", 32'(s_bad), 0);
          check("mosi_zero_at_done", 32'(m), 0);
          check("cs_busy_at_done", 32'({cs, busy}), 32'(2'b10));
          check("latency", 32'(cyc - cs_fall_cyc), 32'((2 * DW / e.w + 1) * CD));
          if (e.t0 >= 0) check("start_to_cs", 32'(cs_fall_cyc), 32'(e.t0));
          if (e.gap) check("b2b_gap", 32'(cs_fall_cyc - last_done_cyc), 2);
        end
        last_done_cyc = cyc;
        active = 0;
      end
      prev_cs   = cs;
      prev_sclk = sclk;
      prev_mosi = m;
    end
  end

  function automatic int lane_w(input logic [1:0] ln);
    return (ln == 2'd2) ? 4 : (ln == 2'd1) ? 2 : 1;
  endfunction

  task automatic xfer(input logic [7:0] tx, input logic [7:0] sw, input logic [1:0] ln,
                      input bit pol, input bit pha);
    @(negedge clk);
    tx_data = tx;
    lanes   = ln;
    cpol    = pol;
    cpha    = pha;
    start   = 1'b1;
    slv_q.push_back('{sw, lane_w(ln), pol, pha});
    exp_q.push_back('{tx, sw, lane_w(ln), cyc + 1, 1'b0});
    exp_dones++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet();
    int i;
    for (i = 0; i < 300 && (exp_q.size() != 0 || busy || done); i++) @(negedge clk);
    if (i >= 300) check("quiet_timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    rst = 1'b1; start = 1'b0; tx_data = '0; lanes = 2'b00; cpol = 1'b0; cpha = 1'b0;
    {miso3, miso2, miso1, miso0} = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({sclk, cs, mosi3, mosi2, mosi1, mosi0, busy, done}),
          32'(8'b0100_0000));
    check("reset_rx_data", 32'(rx_data), 0);
    rst = 1'b0;

    xfer(8'hA5, 8'h3C, 2'b00, 1'b0, 1'b0);
    wait_quiet();
    xfer(8'h5A, 8'hC3, 2'b10, 1'b0, 1'b0);
    wait_quiet();
    xfer(8'h96, 8'h69, 2'b01, 1'b1, 1'b1);
    wait_quiet();
    check("sclk_idle_cpol1", 32'(sclk), 1);

    // Start pulse with a different word and settings while busy must be dropped.
    xfer(8'h3A, 8'hE1, 2'b00, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    tx_data = 8'hFF; lanes = 2'b10; cpol = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cpol = 1'b0;
    wait_quiet();
    repeat (40) @(negedge clk);
    check("single_done_after_ignored_start", 32'(dn_count), 32'(exp_dones));

    // Abort with reset on the fifth SCLK edge.
    @(negedge clk);
    tx_data = 8'hC7; lanes = 2'b00; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    slv_q.push_back('{8'h5F, 1, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pins", 32'({cs, sclk, busy, done, mosi3, mosi2, mosi1, mosi0}),
          32'(8'b1000_0000));
    check("abort_rx_cleared", 32'(rx_data), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    xfer(8'h81, 8'h7E, 2'b10, 1'b1, 1'b0);
    wait_quiet();

    // Two transfers with start held; lanes=11 behaves as single.
    @(negedge clk);
    tx_data = 8'h12; lanes = 2'b11; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    slv_q.push_back('{8'hAB, 1, 1'b0, 1'b0});
    slv_q.push_back('{8'hCD, 1, 1'b0, 1'b0});
    exp_q.push_back('{8'h12, 8'hAB, 1, cyc + 1, 1'b0});
    exp_q.push_back('{8'h34, 8'hCD, 1, -1, 1'b1});
    exp_dones += 2;
    @(negedge clk);
    tx_data = 8'h34;
    for (i = 0; i < 100 && !done; i++) @(negedge clk);
    if (i >= 100) check("held_first_done_timeout", 1, 0);
    @(negedge clk);
    for (i = 0; i < 10 && !busy; i++) @(negedge clk);
    if (i >= 10) check("held_second_start_timeout", 1, 0);
    start = 1'b0;
    wait_quiet();

    repeat (20) @(negedge clk);
    check("done_count", 32'(dn_count), 32'(exp_dones));
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
